// File: rtl/ltc_adc_scan_controller.sv
// ltc_adc_scan_controller: round-robin multi-channel LTC186x scan engine.
// Drives an SPI mode-3 frame per enabled channel and tags each result.
//
// Ports:
//   i_clk, i_rst   system clock, synchronous active-high reset
//   i_en           scan enable
//   i_ch_mask      channel enable mask (bit k = channel k)
//   o_sck/o_scs    SPI clock (idles high) / chip select (active low)
//   o_sdo/i_sdi    command bit out / conversion data in
//   o_data         result of the previously commanded channel
//   o_data_ch      channel index that produced o_data
//   o_data_dv      one-cycle strobe for o_data/o_data_ch
//   o_busy         high while a frame or its conversion wait runs
//   i_trig         (LTC_SCAN_TRIG_EN only) rising edge launches a frame
//
// Optional feature macro: LTC_SCAN_TRIG_EN (triggered rather than
// free-running scan, with one pending trigger latched while busy).
module ltc_adc_scan_controller #(
    parameter int NUM_CH              = 2,
    parameter int CH_W                = 4,
    parameter int XFER_BITS           = 16,
    parameter int DATA_W              = 16,
    parameter int SCK_HALF_PERIOD_CLK = 2,
    parameter int CONV_WAIT_CLK       = 165
) (
    input  logic              i_clk,
    input  logic              i_rst,
`ifdef LTC_SCAN_TRIG_EN
    input  logic              i_trig,
`endif
    input  logic              i_en,
    input  logic [NUM_CH-1:0] i_ch_mask,
    output logic              o_sck,
    output logic              o_scs,
    output logic              o_sdo,
    input  logic              i_sdi,
    output logic [DATA_W-1:0] o_data,
    output logic [CH_W-1:0]   o_data_ch,
    output logic              o_data_dv,
    output logic              o_busy
);

    localparam int CNT_MAX = (CONV_WAIT_CLK > SCK_HALF_PERIOD_CLK) ?
                             CONV_WAIT_CLK : SCK_HALF_PERIOD_CLK;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(XFER_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SCK_HALF_PERIOD_CLK - 1);
    localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_WAIT_CLK - 1);
    localparam logic [BIT_W-1:0] BITS_ALL  = BIT_W'(XFER_BITS);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic [CH_W:0]    NUM_CH_E  = (CH_W + 1)'(NUM_CH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_HOLD
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bits_q, bits_d;
    logic [XFER_BITS-1:0]   cmd_q, cmd_d;
    logic [XFER_BITS-1:0]   rx_q, rx_d;
    logic                   sck_q, sck_d;
    logic                   scs_q, scs_d;
    logic [CH_W-1:0]        cur_ch_q, cur_ch_d;
    logic [CH_W-1:0]        prev_ch_q, prev_ch_d;
    logic [CH_W-1:0]        ptr_q, ptr_d;
    logic                   primed_q, primed_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [CH_W-1:0]        data_ch_q, data_ch_d;
    logic                   dv_q, dv_d;

    logic [2*NUM_CH-1:0]    mask_rot;
    logic [CH_W:0]          sum;
    logic                   found;
    logic [CH_W-1:0]        sel_ch;
    logic [XFER_BITS-1:0]   cmd_new;
    logic [CH_W-1:0]        ptr_next;
    logic                   launch_req;
    logic                   launch;

`ifdef LTC_SCAN_TRIG_EN
    logic trig_q;
    logic pend_q, pend_d;
    logic trig_rise;

    assign trig_rise  = i_trig & ~trig_q;
    assign launch_req = trig_rise | pend_q;
`else
    assign launch_req = 1'b1;
`endif

    assign launch = i_en && (|i_ch_mask) && launch_req;

    // Rotate the mask so that bit 0 is the pointer position; the first
    // set bit then gives the offset of the next channel to scan.
    always_comb begin
        mask_rot = {i_ch_mask, i_ch_mask} >> ptr_q;
        found    = 1'b0;
        sum      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && mask_rot[i]) begin
                found = 1'b1;
                sum   = {1'b0, ptr_q} + (CH_W + 1)'(i);
                if (sum >= NUM_CH_E) begin
                    sum = sum - NUM_CH_E;
                end
            end
        end
        sel_ch = sum[CH_W-1:0];
    end

    always_comb begin
        cmd_new                      = '0;
        cmd_new[XFER_BITS-1]         = 1'b1;
        cmd_new[XFER_BITS-2 -: CH_W] = sel_ch;
    end

    assign ptr_next = (cur_ch_q == CH_LAST) ? '0 : cur_ch_q + CH_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bits_d    = bits_q;
        cmd_d     = cmd_q;
        rx_d      = rx_q;
        sck_d     = sck_q;
        scs_d     = scs_q;
        cur_ch_d  = cur_ch_q;
        prev_ch_d = prev_ch_q;
        ptr_d     = ptr_q;
        primed_d  = primed_q;
        data_d    = data_q;
        data_ch_d = data_ch_q;
        dv_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!i_en) begin
                    primed_d = 1'b0;
                end
                if (launch) begin
                    state_d  = S_SHIFT;
                    scs_d    = 1'b0;
                    sck_d    = 1'b1;
                    cmd_d    = cmd_new;
                    cur_ch_d = sel_ch;
                    // Preloaded so the first SCK low phase starts one
                    // cycle after CS_n falls.
                    cnt_d    = HALF_LAST;
                    bits_d   = '0;
                    rx_d     = '0;
                end
            end
            S_SHIFT: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (sck_q) begin
                        if (bits_q == BITS_ALL) begin
                            state_d   = S_HOLD;
                            scs_d     = 1'b1;
                            cmd_d     = '0;
                            // The ADC answers one frame late, so this
                            // frame's data belongs to the previous channel.
                            if (primed_q) begin
                                dv_d      = 1'b1;
                                data_d    = rx_q[XFER_BITS-1 -: DATA_W];
                                data_ch_d = prev_ch_q;
                            end
                            primed_d  = 1'b1;
                            prev_ch_d = cur_ch_q;
                            ptr_d     = ptr_next;
                        end else begin
                            sck_d = 1'b0;
                            if (bits_q != '0) begin
                                cmd_d = cmd_q << 1;
                            end
                        end
                    end else begin
                        sck_d  = 1'b1;
                        rx_d   = {rx_q[XFER_BITS-2:0], i_sdi};
                        bits_d = bits_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == CONV_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef LTC_SCAN_TRIG_EN
    // One request is remembered while busy; more edges are absorbed.
    always_comb begin
        pend_d = pend_q;
        if (state_q != S_IDLE) begin
            if (trig_rise) begin
                pend_d = 1'b1;
            end
        end else if (launch || !i_en) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            trig_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            trig_q <= i_trig;
            pend_q <= pend_d;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bits_q    <= '0;
            cmd_q     <= '0;
            rx_q      <= '0;
            sck_q     <= 1'b1;
            scs_q     <= 1'b1;
            cur_ch_q  <= '0;
            prev_ch_q <= '0;
            ptr_q     <= '0;
            primed_q  <= 1'b0;
            data_q    <= '0;
            data_ch_q <= '0;
            dv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bits_q    <= bits_d;
            cmd_q     <= cmd_d;
            rx_q      <= rx_d;
            sck_q     <= sck_d;
            scs_q     <= scs_d;
            cur_ch_q  <= cur_ch_d;
            prev_ch_q <= prev_ch_d;
            ptr_q     <= ptr_d;
            primed_q  <= primed_d;
            data_q    <= data_d;
            data_ch_q <= data_ch_d;
            dv_q      <= dv_d;
        end
    end

    assign o_sck     = sck_q;
    assign o_scs     = scs_q;
    assign o_sdo     = cmd_q[XFER_BITS-1];
    assign o_data    = data_q;
    assign o_data_ch = data_ch_q;
    assign o_data_dv = dv_q;
    assign o_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_ltc_adc_scan_controller.sv
// tb_ltc_adc_scan_controller: scoreboard bench with an ADC slave model.
// Expected commands and results are queued; a monitor pops and compares.
module tb_ltc_adc_scan_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  mask;
    logic        sdi = 1'b0;
    logic        o_sck, o_scs, o_sdo;
    logic [15:0] o_data;
    logic [3:0]  o_data_ch;
    logic        o_data_dv, o_busy;
`ifdef LTC_SCAN_TRIG_EN
    logic        trig;
`endif

    always #5 clk = ~clk;

    ltc_adc_scan_controller #(
        .NUM_CH(4),
        .CH_W(4),
        .XFER_BITS(16),
        .DATA_W(16),
        .SCK_HALF_PERIOD_CLK(2),
        .CONV_WAIT_CLK(10)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
`ifdef LTC_SCAN_TRIG_EN
        .i_trig(trig),
`endif
        .i_en(en),
        .i_ch_mask(mask),
        .o_sck(o_sck),
        .o_scs(o_scs),
        .o_sdo(o_sdo),
        .i_sdi(sdi),
        .o_data(o_data),
        .o_data_ch(o_data_ch),
        .o_data_dv(o_data_dv),
        .o_busy(o_busy)
    );

    typedef struct packed {
        logic [3:0]  ch;
        logic [15:0] data;
    } dv_t;

    dv_t         exp_dv[$];
    logic [15:0] exp_cmd[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] adc_val(input logic [3:0] ch);
        case (ch)
            4'd0:    adc_val = 16'hA5C3;
            4'd1:    adc_val = 16'h5A3C;
            4'd3:    adc_val = 16'hC35A;
            default: adc_val = 16'h0F0F;
        endcase
    endfunction

    // Monitor / slave state
    int          cyc = 0;
    int          n_falls = 0;
    int          rise_cnt = 0;
    int          sfall = 0;
    int          last_fall = 0;
    bit          have_last = 0;
    bit          rst_in_win = 0;
    logic        prev_scs = 1'b1;
    logic        prev_sck = 1'b1;
    logic        prev_sdo = 1'b0;
    logic [15:0] cmd_word = '0;
    logic [15:0] tx = '0;
    logic [3:0]  slave_last_ch = 4'd0;
    dv_t         e;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            rst_in_win = 1;
            have_last  = 0;
        end
        if (!en) have_last = 0;
        if (prev_scs && !o_scs) begin
            n_falls++;
            rise_cnt   = 0;
            cmd_word   = '0;
            sfall      = 0;
            rst_in_win = 0;
            // The ADC returns the conversion of the last command.
            tx  = adc_val(slave_last_ch);
            sdi = tx[15];
            if (have_last) chk("scs_period", cyc - last_fall, 76);
            last_fall = cyc;
            have_last = 1;
        end
        if (!prev_scs && !o_scs) begin
            if (!prev_sck && o_sck) begin
                rise_cnt++;
                cmd_word = {cmd_word[14:0], o_sdo};
            end
            if (prev_sck && !o_sck) begin
                if (sfall > 0) tx = tx << 1;
                sfall++;
                sdi = tx[15];
            end
            if (o_sdo !== prev_sdo) chk("sdo_chg_sck_low", o_sck, 0);
        end
        if (!prev_scs && o_scs && !rst_in_win) begin
            chk("sck_rises", rise_cnt, 16);
            if (exp_cmd.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame cmd=%h", cmd_word);
            end else begin
                chk("cmd_word", cmd_word, exp_cmd.pop_front());
            end
            slave_last_ch = cmd_word[14:11];
        end
        if (o_data_dv) begin
            if (exp_dv.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_dv ch=%0h data=%h",
                         o_data_ch, o_data);
            end else begin
                e = exp_dv.pop_front();
                chk("dv_ch", o_data_ch, e.ch);
                chk("dv_data", o_data, e.data);
            end
        end
        prev_scs = o_scs;
        prev_sck = o_sck;
        prev_sdo = o_sdo;
    end

    task automatic wait_falls(input int n, input int lim);
        int t = 0;
        while (n_falls < n && t < lim) begin
            @(negedge clk);
            t++;
        end
        if (n_falls < n) begin
            checks++;
            failures++;
            $display("FAIL wait_falls got=%0d want=%0d", n_falls, n);
        end
    endtask

    task automatic wait_rises(input int n, input int lim);
        int t = 0;
        while ((o_scs || rise_cnt < n) && t < lim) begin
            @(negedge clk);
            t++;
        end
        if (o_scs || rise_cnt < n) begin
            checks++;
            failures++;
            $display("FAIL wait_rises got=%0d want=%0d", rise_cnt, n);
        end
    endtask

    task automatic push_dv(input logic [3:0] ch, input logic [15:0] d);
        dv_t x;
        x.ch   = ch;
        x.data = d;
        exp_dv.push_back(x);
    endtask

    initial begin
        int t;
        rst  = 1'b1;
        en   = 1'b0;
        mask = 4'b0000;
`ifdef LTC_SCAN_TRIG_EN
        trig = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_sck", o_sck, 1);
        chk("rst_scs", o_scs, 1);
        chk("rst_sdo", o_sdo, 0);
        chk("rst_data", o_data, 0);
        chk("rst_data_ch", o_data_ch, 0);
        chk("rst_dv", o_data_dv, 0);
        chk("rst_busy", o_busy, 0);
        rst = 1'b0;

`ifdef LTC_SCAN_TRIG_EN
        exp_cmd.push_back(16'h8000);
        exp_cmd.push_back(16'h8800);
        push_dv(4'd0, 16'hA5C3);
        mask = 4'b1011;
        en   = 1'b1;
        repeat (5) @(negedge clk);
        chk("trig_idle_nolaunch", n_falls, 0);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        wait_falls(1, 20);
        repeat (20) @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        repeat (400) @(negedge clk);
        chk("trig_frames", n_falls, 2);
        chk("trig_cmd_left", exp_cmd.size(), 0);
        chk("trig_dv_left", exp_dv.size(), 0);
`else
        // Free scan over mask 1011: ch 0,1,3,0,1 then abort in frame 6
        exp_cmd.push_back(16'h8000);
        exp_cmd.push_back(16'h8800);
        exp_cmd.push_back(16'h9800);
        exp_cmd.push_back(16'h8000);
        exp_cmd.push_back(16'h8800);
        push_dv(4'd0, 16'hA5C3);
        push_dv(4'd1, 16'h5A3C);
        push_dv(4'd3, 16'hC35A);
        push_dv(4'd0, 16'hA5C3);
        mask = 4'b1011;
        en   = 1'b1;
        wait_falls(6, 600);
        wait_rises(7, 100);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_scs", o_scs, 1);
        chk("midrst_sck", o_sck, 1);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_dv", o_data_dv, 0);
        chk("midrst_cmd_left", exp_cmd.size(), 0);
        chk("midrst_dv_left", exp_dv.size(), 0);
        @(negedge clk);
        rst = 1'b0;

        // Restart from ch0 with a fresh priming frame, then drop i_en
        exp_cmd.push_back(16'h8000);
        exp_cmd.push_back(16'h8800);
        exp_cmd.push_back(16'h9800);
        push_dv(4'd0, 16'hA5C3);
        push_dv(4'd1, 16'h5A3C);
        wait_falls(9, 300);
        wait_rises(3, 100);
        en = 1'b0;
        t = 0;
        while (o_busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (o_busy) begin
            checks++;
            failures++;
            $display("FAIL busy_fall got=1 want=0");
        end
        chk("endis_cmd_left", exp_cmd.size(), 0);
        chk("endis_dv_left", exp_dv.size(), 0);
        repeat (300) @(negedge clk);
        chk("no_relaunch", n_falls, 9);
        chk("idle_scs", o_scs, 1);

        mask = 4'b0000;
        en   = 1'b1;
        repeat (1000) @(negedge clk);
        chk("mask0_falls", n_falls, 9);
        chk("mask0_scs", o_scs, 1);
        chk("mask0_busy", o_busy, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
